jk_seq_counter_ctrl: RTL and testbench
======================================

Name: jk_seq_counter_ctrl

Overview:
- Controller that sequences a WIDTH-bit register built from JK flip-flop cells (next = J&~q | ~K&q per bit).
- Each cycle it computes per-bit J/K drive to load a start value, count up or down, hold, or clear.
- A start/busy/done handshake runs one counting job from start_val to end_val.
- Sits above the JK/T flip-flop primitives as their sequencer; J/K vectors are exported for observability.

Parameters:
WIDTH, 4, number of JK bits in the counted register (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; 0 = reset asserted
start  input  1  request a job; sampled only in IDLE
abort  input  1  cancel job; clears register; highest priority after reset
dir  input  1  1 = count up, 0 = count down; sampled at start and held internally for the job
en  input  1  count enable in RUN; 0 = hold
start_val  input  WIDTH  value loaded in LOAD; captured at start
end_val  input  WIDTH  terminal value; captured at start
q  output  WIDTH  JK register contents
jk_j  output  WIDTH  J drive applied this cycle (combinational from state/q)
jk_k  output  WIDTH  K drive applied this cycle
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (reset=0, async): state=IDLE, q=0, captured dir/start_val/end_val=0, busy=0, done=0, jk_j=0, jk_k=0.
- States: IDLE, LOAD, RUN, DONE (2-bit encoding).
- J/K drive per state:
  - IDLE, DONE: J=K=0 (hold).
  - LOAD: J=start_val_r, K=~start_val_r.
  - RUN with en=1 and q!=end_val_r: J=K=t, where t[0]=1.
    - Up: t[i]=&q[i-1:0].
    - Down: t[i]=&~q[i-1:0].
  - RUN with en=0 or q==end_val_r: J=K=0.
  - Abort (any state): J=0, K=all-ones.
- IDLE: start=1 → capture dir/start_val/end_val, go to LOAD.
- LOAD: one cycle. q=start_val_r at the next edge; go to RUN.
- RUN:
  - q==end_val_r → go to DONE (no step taken).
  - Otherwise step when en=1, stay in RUN.
- DONE: done=1 for exactly one cycle, go to IDLE; q retains end value.
- Latency: N = steps from start to end (mod 2^WIDTH in the chosen direction), with en held high. done is high during the cycle after edge N+3 counted from the edge that samples start. With en gaps, latency grows by one cycle per low cycle.
- Wrap-around: up from all-ones → 0; down from 0 → all-ones. Counting continues until end_val is reached, so every job terminates.
- start_val==end_val: LOAD → RUN → DONE with zero steps; done at edge 3.
- start while busy or in DONE: ignored; inputs not recaptured.
- abort=1 in any state: next edge q=0, state=IDLE, done not asserted. abort in IDLE also clears q. abort beats start in the same cycle.
- Changes on dir/start_val/end_val during a job have no effect (captured copies used).
- Reset asserted mid-job: immediate return to reset values. After deassertion, waits in IDLE for a new start.

Test Plan:
- WIDTH=4, start_val=3, end_val=7, dir=1, en=1, start pulse → q 3,4,5,6,7; busy high 6 cycles; done pulses 1 cycle at edge 7; q stays 7.
- start_val=1, end_val=14, dir=0 → q 1,0,15,14; wrap observed; done at edge 6; jk_j=jk_k=4'b1111 on the 0→15 step.
- start_val=2, end_val=6, dir=1, en low for 2 cycles mid-RUN → q holds with jk_j=jk_k=0; done delayed 2 cycles, at edge 9.
- start_val=end_val=9 → no count steps; done at edge 3; second start during busy is ignored with no recapture.
- Job running at q=5, abort=1 together with start=1 → q=0, IDLE, no done; reset=0 mid-RUN clears q/busy/done asynchronously, before the next clock edge.

Source files
------------

// File: rtl/jk_seq_counter_ctrl.sv
// Sequencer for a WIDTH-bit register of JK cells: load, count up/down, hold or clear,
// with a start/busy/done handshake that runs one counting job from start_val to end_val.
module jk_seq_counter_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             en,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_val_q, end_val_q;
    logic             dir_q;
    logic             capture;
    logic             at_end;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] j, k;

    assign at_end = (q_q == end_val_q);

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t    = '0;
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & (dir_q ? q_q[i-1] : ~q_q[i-1]);
        end
    end

    always_comb begin
        state_d = state_q;
        j       = '0;
        k       = '0;
        capture = 1'b0;
        if (abort) begin
            state_d = StIdle;
            k       = '1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        capture = 1'b1;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    j       = start_val_q;
                    k       = ~start_val_q;
                    state_d = StRun;
                end
                StRun: begin
                    if (at_end) begin
                        state_d = StDone;
                    end else if (en) begin
                        j = t;
                        k = t;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Characteristic equation of the JK cells, applied bitwise.
    assign q_d = (j & ~q_q) | (~k & q_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            q_q         <= '0;
            dir_q       <= 1'b0;
            start_val_q <= '0;
            end_val_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            if (capture) begin
                dir_q       <= dir;
                start_val_q <= start_val;
                end_val_q   <= end_val;
            end
        end
    end

    assign q    = q_q;
    assign jk_j = j;
    assign jk_k = k;
    assign busy = (state_q == StLoad) || (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_jk_seq_counter_ctrl.sv
// Scoreboard bench: a cycle model pushes expected outputs as each cycle is driven;
// a negedge monitor pops and compares them against the DUT.
module tb_jk_seq_counter_ctrl;

    localparam logic [1:0] MIdle = 2'd0;
    localparam logic [1:0] MLoad = 2'd1;
    localparam logic [1:0] MRun  = 2'd2;
    localparam logic [1:0] MDone = 2'd3;

    typedef struct {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic [3:0] j;
        logic [3:0] k;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       dir;
    logic       en;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic [3:0] q;
    logic [3:0] jk_j;
    logic [3:0] jk_k;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    exp_t e_mon;

    logic [1:0] ms;
    logic [3:0] mq, msv, mev;
    logic       mdir;

    jk_seq_counter_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .dir       (dir),
        .en        (en),
        .start_val (start_val),
        .end_val   (end_val),
        .q         (q),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e_mon = sb_q.pop_front();
            check_val("q", {28'd0, q}, {28'd0, e_mon.q});
            check_val("busy", {31'd0, busy}, {31'd0, e_mon.busy});
            check_val("done", {31'd0, done}, {31'd0, e_mon.done});
            check_val("jk_j", {28'd0, jk_j}, {28'd0, e_mon.j});
            check_val("jk_k", {28'd0, jk_k}, {28'd0, e_mon.k});
        end
    end

    task automatic model_reset();
        ms   = MIdle;
        mq   = 4'd0;
        msv  = 4'd0;
        mev  = 4'd0;
        mdir = 1'b0;
    endtask

    // One clock cycle: drive inputs, push expected outputs, advance model at the edge.
    task automatic step(input logic s, input logic a, input logic d, input logic e,
                        input logic [3:0] sv, input logic [3:0] ev);
        exp_t       x;
        logic [3:0] nxt;
        start     = s;
        abort     = a;
        dir       = d;
        en        = e;
        start_val = sv;
        end_val   = ev;
        nxt       = mdir ? mq + 4'd1 : mq - 4'd1;
        x.q       = mq;
        x.busy    = (ms == MLoad) || (ms == MRun);
        x.done    = (ms == MDone);
        x.j       = 4'd0;
        x.k       = 4'd0;
        if (a) begin
            x.k = 4'hf;
        end else if (ms == MLoad) begin
            x.j = msv;
            x.k = ~msv;
        end else if (ms == MRun && e && mq != mev) begin
            x.j = mq ^ nxt;
            x.k = mq ^ nxt;
        end
        sb_q.push_back(x);
        @(posedge clk);
        if (a) begin
            ms = MIdle;
            mq = 4'd0;
        end else begin
            case (ms)
                MIdle: if (s) begin
                    ms   = MLoad;
                    mdir = d;
                    msv  = sv;
                    mev  = ev;
                end
                MLoad: begin
                    mq = msv;
                    ms = MRun;
                end
                MRun: begin
                    if (mq == mev) ms = MDone;
                    else if (e) mq = nxt;
                end
                default: ms = MIdle;
            endcase
        end
        #1;
    endtask

    // Edge 1 samples start; returns the edge number after which done is first seen.
    task automatic run_job(input logic [3:0] sv, input logic [3:0] ev, input logic d,
                           input int gap_lo, input int gap_hi, input logic restart,
                           input int exp_edge, input string tag);
        int   found;
        logic en_v;
        logic s_v;
        found = 99;
        step(1'b1, 1'b0, d, 1'b1, sv, ev);
        for (int e = 2; e <= 40; e++) begin
            en_v = !(e >= gap_lo && e <= gap_hi);
            s_v  = restart && (e == 2 || e == 4);
            // Perturb the live inputs; only captured copies may matter.
            step(s_v, 1'b0, ~d, en_v, ~sv, ~ev);
            if (done) begin
                found = e;
                break;
            end
        end
        check_val({tag, "_done_edge"}, found, exp_edge);
        step(1'b0, 1'b0, d, 1'b1, sv, ev);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        dir       = 1'b0;
        en        = 1'b0;
        start_val = 4'd0;
        end_val   = 4'd0;
        model_reset();
        #12;
        check_val("rst_q", {28'd0, q}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_j", {28'd0, jk_j}, 32'd0);
        check_val("rst_k", {28'd0, jk_k}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

        run_job(4'd3, 4'd7, 1'b1, 0, 0, 1'b0, 7, "up_3_7");
        check_val("hold_end", {28'd0, q}, 32'd7);
        // Abort while idle must clear the retained value.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

        run_job(4'd1, 4'd14, 1'b0, 0, 0, 1'b0, 6, "down_wrap");
        run_job(4'd2, 4'd6, 1'b1, 4, 5, 1'b0, 9, "en_gap");
        run_job(4'd9, 4'd9, 1'b1, 0, 0, 1'b1, 3, "equal");
        check_val("equal_keep", {28'd0, q}, 32'd9);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

        // Abort together with start while running at q=5.
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd12);
        for (int i = 0; i < 10 && !(ms == MRun && mq == 4'd5); i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd12);
        end
        check_val("abort_at5", {28'd0, q}, 32'd5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd12);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

        // Asynchronous reset mid-RUN.
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 4'd11);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd11);
        check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #2;
        check_val("arst_q", {28'd0, q}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_done", {31'd0, done}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd11);

        @(negedge clk);
        #1;
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
